// File: rtl/ysyx_22050854_divider_seq.sv
// ysyx_22050854_divider_seq: 64-bit radix-2 restoring divider for RV64M (DIV/DIVU/REM/REMU and W forms).
// Define DIV_SPECIAL_FAST_EN to resolve divide-by-zero and signed overflow in one cycle.
module ysyx_22050854_divider_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        div_valid,
   output logic        div_ready,
   input  logic        div_signed,
   input  logic        div_word,
   input  logic [63:0] dividend,
   input  logic [63:0] divisor,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] quotient,
   output logic [63:0] remainder
);
`ifdef DIV_SPECIAL_FAST_EN
   localparam logic FAST = 1'b1;
`else
   localparam logic FAST = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nx;
   logic [63:0] dvd, dvs, rem, orig;
   logic [5:0]  cnt;
   logic        q_neg, r_neg, word, div0, special;
   logic [63:0] a_eff, b_eff, a_abs, b_abs, q_raw, rem_nx, q_fin, r_fin;
   logic [64:0] shifted, diff;
   logic        a_neg, b_neg, is_div0, is_ovf, special_in, accept, ge;

   function automatic logic [63:0] fin(input logic [63:0] x, input logic w);
      return w ? {{32{x[31]}}, x[31:0]} : x;
   endfunction

   assign div_ready  = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign accept     = div_valid & div_ready & ~flush;
   assign a_eff      = div_word ? {{32{div_signed & dividend[31]}}, dividend[31:0]} : dividend;
   assign b_eff      = div_word ? {{32{div_signed & divisor[31]}}, divisor[31:0]} : divisor;
   assign a_neg      = div_signed & a_eff[63];
   assign b_neg      = div_signed & b_eff[63];
   assign a_abs      = a_neg ? -a_eff : a_eff;
   assign b_abs      = b_neg ? -b_eff : b_eff;
   assign is_div0    = (b_eff == 64'd0);
   assign is_ovf     = div_signed & (&b_eff) &
                       (a_eff == (div_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
   assign special_in = is_div0 | is_ovf;
   // One restoring step: shift in the next dividend bit, keep the difference if non-negative
   assign shifted    = {rem, dvd[63]};
   assign diff       = shifted - {1'b0, dvs};
   assign ge         = ~diff[64];
   assign rem_nx     = ge ? diff[63:0] : shifted[63:0];
   assign q_raw      = {dvd[62:0], ge};
   assign q_fin      = special ? (div0 ? 64'hFFFF_FFFF_FFFF_FFFF : orig) : (q_neg ? -q_raw : q_raw);
   assign r_fin      = special ? (div0 ? orig : 64'd0) : (r_neg ? -rem_nx : rem_nx);

   always_comb begin
      state_nx = state;
      if (flush) state_nx = IDLE;
      else if (state == IDLE && div_valid) state_nx = (FAST && special_in) ? DONE : CALC;
      else if (state == CALC && (&cnt)) state_nx = DONE;
      else if (state == DONE && out_ready) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd       <= '0;
         dvs       <= '0;
         rem       <= '0;
         orig      <= '0;
         cnt       <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         word      <= 1'b0;
         div0      <= 1'b0;
         special   <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else if (accept) begin
         dvd     <= a_abs;
         dvs     <= b_abs;
         rem     <= '0;
         orig    <= a_eff;
         cnt     <= '0;
         q_neg   <= a_neg ^ b_neg;
         r_neg   <= a_neg;
         word    <= div_word;
         div0    <= is_div0;
         special <= special_in;
         if (FAST && special_in) begin
            quotient  <= fin(is_div0 ? 64'hFFFF_FFFF_FFFF_FFFF : a_eff, div_word);
            remainder <= fin(is_div0 ? a_eff : 64'd0, div_word);
         end
      end else if (state == CALC && !flush) begin
         dvd <= q_raw;
         rem <= rem_nx;
         cnt <= cnt + 6'd1;
         if (&cnt) begin
            quotient  <= fin(q_fin, word);
            remainder <= fin(r_fin, word);
         end
      end
   end
endmodule

// File: tb/tb_ysyx_22050854_divider_seq.sv
// tb_ysyx_22050854_divider_seq: directed checks of the sequential divider.
// Special-case latency expectations follow DIV_SPECIAL_FAST_EN.
module tb_ysyx_22050854_divider_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        div_valid = 1'b0;
   logic        div_ready;
   logic        div_signed = 1'b0;
   logic        div_word = 1'b0;
   logic [63:0] dividend = '0;
   logic [63:0] divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] quotient;
   logic [63:0] remainder;
   int tests = 0;
   int fails = 0;
`ifdef DIV_SPECIAL_FAST_EN
   localparam int SP_LAT = 1;
`else
   localparam int SP_LAT = 65;
`endif

   ysyx_22050854_divider_seq dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .div_valid(div_valid), .div_ready(div_ready),
      .div_signed(div_signed), .div_word(div_word), .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient), .remainder(remainder)
   );

   always #5 clk = ~clk;

   task automatic start(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w);
      int g = 0;
      while (!div_ready && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      dividend = a; divisor = b; div_signed = s; div_word = w; div_valid = 1'b1;
      @(posedge clk); #1;
      div_valid = 1'b0;
   endtask

   task automatic run_div(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                          output logic [63:0] q, output logic [63:0] r, output int lat);
      start(a, b, s, w);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      q = quotient; r = remainder;
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid got %b want 0", out_valid); end
      tests++; if (div_ready !== 1'b1) begin fails++; $display("FAIL reset div_ready got %b want 1", div_ready); end
      tests++; if (quotient !== 64'd0) begin fails++; $display("FAIL reset quotient got %h want 0", quotient); end
      tests++; if (remainder !== 64'd0) begin fails++; $display("FAIL reset remainder got %h want 0", remainder); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_div(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic s, input logic w, input logic [63:0] eq, input logic [63:0] er,
                           input int elat);
      logic [63:0] q, r;
      int lat;
      run_div(a, b, s, w, q, r, lat);
      tests++; if (lat !== elat) begin fails++; $display("FAIL %s latency got %0d want %0d", name, lat, elat); end
      tests++; if (q !== eq) begin fails++; $display("FAIL %s quotient got %h want %h", name, q, eq); end
      tests++; if (r !== er) begin fails++; $display("FAIL %s remainder got %h want %h", name, r, er); end
      pop();
   endtask

   task automatic test_backpressure();
      logic [63:0] q, r;
      int lat;
      run_div(64'd100, 64'd7, 1'b0, 1'b0, q, r, lat);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         tests++;
         if (quotient !== 64'd14 || remainder !== 64'd2 || out_valid !== 1'b1 || div_ready !== 1'b0) begin
            fails++;
            $display("FAIL backpressure cycle %0d got q=%h r=%h v=%b rdy=%b want q=e r=2 v=1 rdy=0",
                     i, quotient, remainder, out_valid, div_ready);
         end
      end
      pop();
      tests++; if (div_ready !== 1'b1) begin fails++; $display("FAIL handshake div_ready got %b want 1", div_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL handshake out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_flush();
      int seen = 0;
      start(64'd1000, 64'd3, 1'b0, 1'b0);
      repeat (29) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      tests++; if (div_ready !== 1'b1) begin fails++; $display("FAIL flush div_ready got %b want 1", div_ready); end
      for (int i = 0; i < 80; i++) begin
         if (out_valid) seen++;
         @(posedge clk); #1;
      end
      tests++; if (seen !== 0) begin fails++; $display("FAIL flush out_valid cycles got %0d want 0", seen); end
      test_div("after_flush 9/3", 64'd9, 64'd3, 1'b0, 1'b0, 64'd3, 64'd0, 65);
   endtask

   task automatic test_reset_mid();
      start(64'd100, 64'd7, 1'b0, 1'b0);
      repeat (20) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset out_valid got %b want 0", out_valid); end
      tests++; if (div_ready !== 1'b1) begin fails++; $display("FAIL midreset div_ready got %b want 1", div_ready); end
      tests++; if (quotient !== 64'd0) begin fails++; $display("FAIL midreset quotient got %h want 0", quotient); end
      tests++; if (remainder !== 64'd0) begin fails++; $display("FAIL midreset remainder got %h want 0", remainder); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_div("udiv 100/7", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65);
      test_div("sdiv -100/7", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      test_div("sdiv 100/-7", 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 65);
      test_div("divw overflow", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1,
               64'hFFFF_FFFF_8000_0000, 64'd0, SP_LAT);
      test_div("divuw ffffffff/2", 64'h0000_0000_FFFF_FFFF, 64'd2, 1'b0, 1'b1,
               64'h0000_0000_7FFF_FFFF, 64'd1, 65);
      test_div("div by zero", 64'h1234, 64'd0, 1'b0, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, SP_LAT);
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_div("after_reset 100/7", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
